ts_arbiter: RTL and testbench
=============================

# ts_arbiter

Packet-aligned arbiter that shares the DVB-T2 transmitter's single TS byte input between two TS sources, for example the internal pattern generator and an external TS feed. It sits between the sources and the transmitter's `idat/isop/ival/ordy` port. Grants are changed only on 188-byte packet boundaries. When neither source has a packet ready, it can insert MPEG null packets so the modulator never starves.

## Interface
- `PKT_LEN`, 188: TS packet length in bytes.
- `CNT_W`, 16: width of the statistics counters.
- `iclk`  in  1  Single clock for the whole block.
- `irst`  in  1  Synchronous, active-high reset.
- `imode`  in  1  Arbitration mode: 0 = round-robin, 1 = strict priority to source 0. Sampled only in IDLE.
- `idat0`/`isop0`/`ival0`  in  8/1/1  Source 0 byte, start-of-packet and valid.
- `ordy0`  out  1  Source 0 ready. A byte moves when `ival0 & ordy0`.
- `idat1`/`isop1`/`ival1`  in  8/1/1  Source 1 byte, start-of-packet and valid.
- `ordy1`  out  1  Source 1 ready.
- `odat`/`osop`/`oval`  out  8/1/1  Byte stream to the transmitter.
- `irdy`  in  1  Transmitter ready. A byte moves when `oval & irdy`.
- `ogrant`  out  2  Current owner: 0 = none, 1 = source 0, 2 = source 1, 3 = null generator.
- `onull_cnt`  out  CNT_W  Number of null packets inserted. Saturates.
- `odrop_cnt`  out  CNT_W  Number of source bytes discarded for resync. Saturates.
- `osync_err`  out  1  One-cycle pulse when a granted source asserts `isop` at a byte index other than 0.

## Operation
- States: IDLE, SRC0, SRC1, NULL. A byte index `cnt` runs 0..PKT_LEN-1.
- IDLE:
  - A source is a candidate when its `ival & isop` are both high.
  - If there are two candidates, imode=1 picks source 0. imode=0 picks the source that was not granted last; `last` resets to source 1, so source 0 wins first.
  - Granting sets `cnt` to 0 and moves to SRC0 or SRC1 on the next cycle.
  - If there is no candidate and `irdy`=1, move to NULL (null insertion only; see Configuration).
  - A source presenting `ival`=1 with `isop`=0 gets `ordy`=1 and the byte is discarded; `odrop_cnt` increments. This resyncs the source to a packet start.
- SRCn:
  - `odat/osop/oval` are combinationally forwarded from source n. `ordyn` = `irdy`. The other source sees `ordy`=0.
  - `cnt` increments on each transfer.
  - `isop` seen at `cnt`≠0: the byte is still forwarded, `osop` is forced to 0 and `osync_err` pulses. The packet length is preserved.
  - The transfer with `cnt`=PKT_LEN-1 returns the FSM to IDLE and updates `last`.
- NULL:
  - `oval`=1 and `osop` = (`cnt`==0).
  - `odat` sequence: 0x47, 0x1F, 0xFF, 0x10, then 0xFF for all remaining bytes.
  - `cnt` advances on `irdy`. At PKT_LEN-1 the FSM returns to IDLE and `onull_cnt` increments.
  - Source ready is 0 during NULL, apart from the IDLE-style discard, which is not applied here.
- Statistics counters saturate at all-ones.
- `imode` changes are ignored mid-packet.

## Timing
- Reset values:
  - State IDLE, `cnt`=0, `last`=1.
  - `odat`=0, `osop`=0, `oval`=0, `ordy0`=0, `ordy1`=0.
  - `ogrant`=0, both counters 0, `osync_err`=0.
- Forwarding latency from source to `odat` is 0 cycles; the path is combinational.
- Each granted packet costs exactly one IDLE cycle (bubble) before its first byte moves.
- Back-to-back packets therefore take PKT_LEN+1 cycles when `irdy` is held high.
- `irdy`=0 stalls every state and `cnt` holds.
- If a source drops `ival` mid-packet, `oval` drops with it and the grant is held.
- Reset asserted mid-packet returns to IDLE on the next edge. The partial packet is abandoned, and no padding is generated.
- Simultaneous discard and grant: in the IDLE cycle where one source is granted, the other source may still be discarding its non-SOP byte.

## Configuration
- `TS_ARB_NULL_EN` defined: NULL state, null byte generation and `onull_cnt` are compiled in.
- `TS_ARB_NULL_EN` undefined:
  - The NULL state is removed, and IDLE waits with `oval`=0 until a candidate appears.
  - `onull_cnt` is tied to 0.
  - `ogrant` never reads 3.

## Structure
- Shared package `ts_pkg`:
  - Constants TS_SYNC=8'h47, TS_PKT_LEN=188, TS_NULL_PID=13'h1FFF.
  - State enum type `ts_arb_state_t`.
- One sub-module, `ts_null_gen`: maps `cnt` to the null packet byte. It is instantiated only under `TS_ARB_NULL_EN`.

## Test plan
- Source 0 only, continuous, `irdy`=1: packets start with 0x47, `osop` every 189 cycles, `ogrant`=1, no drops.
- Both sources continuous, imode=0: grants alternate 1,2,1,2. With imode=1, `ogrant` stays 1 for 4 packets.
- No sources, `TS_ARB_NULL_EN` on: output bytes 0x47,0x1F,0xFF,0x10,0xFF×184, and after 3 packets `onull_cnt`=3. With the macro off, `oval` stays 0.
- Source 1 starts mid-packet with 5 non-SOP bytes, then a SOP: `odrop_cnt`=5 and the first forwarded byte has `osop`=1.
- Granted source asserts `isop` at byte 100: `osync_err` pulses once, `osop`=0, and the packet still ends at byte 187.
- `irdy` toggled randomly, plus `irst` pulsed at byte 50 of a packet: no byte is lost or duplicated under stalls, and after reset all outputs are 0 and the FSM is in IDLE on the next cycle.

Source files
------------

// File: rtl/ts_pkg.sv
// ts_pkg: transport-stream constants and the arbiter state type shared by
// the TS arbiter and its null packet generator.
package ts_pkg;

    localparam logic [7:0]  TS_SYNC     = 8'h47;
    localparam int          TS_PKT_LEN  = 188;
    localparam logic [12:0] TS_NULL_PID = 13'h1FFF;

    // Encoding doubles as the ogrant code (0 none, 1 src0, 2 src1, 3 null)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SRC0 = 2'd1,
        ST_SRC1 = 2'd2,
        ST_NULL = 2'd3
    } ts_arb_state_t;

endpackage

// File: rtl/ts_null_gen.sv
// ts_null_gen: maps a packet byte index to the byte of an MPEG null packet.
// Header is sync, PID 0x1FFF with TEI/PUSI/priority clear, payload-only with
// continuity counter 0; every remaining byte is 0xFF stuffing.
module ts_null_gen
    import ts_pkg::*;
#(
    parameter int IDX_W = 8
) (
    input  logic [IDX_W-1:0] cnt,
    output logic [7:0]       null_byte
);

    // Header lookup with 0xFF stuffing for the payload
    always_comb begin
        null_byte = 8'hFF;
        case (cnt)
            IDX_W'(0): null_byte = TS_SYNC;
            IDX_W'(1): null_byte = {3'b000, TS_NULL_PID[12:8]};
            IDX_W'(2): null_byte = TS_NULL_PID[7:0];
            IDX_W'(3): null_byte = 8'h10;
            default:   null_byte = 8'hFF;
        endcase
    end

endmodule

// File: rtl/ts_arbiter.sv
// ts_arbiter: shares one TS byte port between two sources, switching owners
// only on packet boundaries. Define TS_ARB_NULL_EN to compile in null packet
// insertion (NULL state, ts_null_gen and onull_cnt).
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | between packets; grant a SOP candidate, discard non-SOP bytes
// SRC0  | forwarding one packet from source 0
// SRC1  | forwarding one packet from source 1
// NULL  | emitting one null packet (TS_ARB_NULL_EN builds only)
module ts_arbiter
    import ts_pkg::*;
#(
    parameter int PKT_LEN = TS_PKT_LEN,
    parameter int CNT_W   = 16
) (
    input  logic             iclk,
    input  logic             irst,
    input  logic             imode,
    input  logic [7:0]       idat0,
    input  logic             isop0,
    input  logic             ival0,
    output logic             ordy0,
    input  logic [7:0]       idat1,
    input  logic             isop1,
    input  logic             ival1,
    output logic             ordy1,
    output logic [7:0]       odat,
    output logic             osop,
    output logic             oval,
    input  logic             irdy,
    output logic [1:0]       ogrant,
    output logic [CNT_W-1:0] onull_cnt,
    output logic [CNT_W-1:0] odrop_cnt,
    output logic             osync_err
);

    localparam int               IDX_W    = $clog2(PKT_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

    ts_arb_state_t    state;
    logic [IDX_W-1:0] cnt;
    logic             last;       // 1: source 1 owned the previous packet
    logic [CNT_W-1:0] drop_cnt;
    logic             sync_err;

    logic             cand0;
    logic             cand1;
    logic             drop0;
    logic             drop1;
    logic             xfer;
    logic             src_sop;
    logic [CNT_W:0]   drop_sum;

    assign cand0 = ival0 & isop0;
    assign cand1 = ival1 & isop1;

    // A non-SOP byte offered while idle is swallowed so the source realigns
    assign drop0 = (state == ST_IDLE) & ival0 & ~isop0;
    assign drop1 = (state == ST_IDLE) & ival1 & ~isop1;

    // Both sources can discard in the same cycle, hence the two-term sum
    assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);

`ifdef TS_ARB_NULL_EN
    logic [7:0]       null_byte;
    logic [CNT_W-1:0] null_cnt;

    ts_null_gen #(
        .IDX_W (IDX_W)
    ) u_null_gen (
        .cnt       (cnt),
        .null_byte (null_byte)
    );

    assign onull_cnt = null_cnt;
`else
    assign onull_cnt = '0;
`endif

    // Output mux: granted source passes straight through with zero latency
    always_comb begin
        odat    = '0;
        osop    = 1'b0;
        oval    = 1'b0;
        ordy0   = 1'b0;
        ordy1   = 1'b0;
        src_sop = 1'b0;
        case (state)
            ST_IDLE: begin
                ordy0 = drop0;
                ordy1 = drop1;
            end
            ST_SRC0: begin
                odat    = idat0;
                oval    = ival0;
                src_sop = isop0;
                osop    = isop0 & (cnt == '0);
                ordy0   = irdy;
            end
            ST_SRC1: begin
                odat    = idat1;
                oval    = ival1;
                src_sop = isop1;
                osop    = isop1 & (cnt == '0);
                ordy1   = irdy;
            end
`ifdef TS_ARB_NULL_EN
            ST_NULL: begin
                odat = null_byte;
                oval = 1'b1;
                osop = (cnt == '0);
            end
`endif
            default: ;
        endcase
    end

    assign xfer = oval & irdy;

    // Packet sequencing, round-robin history and saturating statistics
    always_ff @(posedge iclk) begin
        if (irst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= 1'b1;
            drop_cnt <= '0;
            sync_err <= 1'b0;
`ifdef TS_ARB_NULL_EN
            null_cnt <= '0;
`endif
        end else begin
            sync_err <= 1'b0;
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (cand0 && cand1) begin
                        state <= (imode || last) ? ST_SRC0 : ST_SRC1;
                    end else if (cand0) begin
                        state <= ST_SRC0;
                    end else if (cand1) begin
                        state <= ST_SRC1;
                    end
`ifdef TS_ARB_NULL_EN
                    else if (irdy) begin
                        state <= ST_NULL;
                    end
`endif
                end
                ST_SRC0, ST_SRC1: begin
                    if (xfer) begin
                        if (src_sop && (cnt != '0)) begin
                            sync_err <= 1'b1;
                        end
                        if (cnt == IDX_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            last  <= (state == ST_SRC1);
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
`ifdef TS_ARB_NULL_EN
                ST_NULL: begin
                    if (irdy) begin
                        if (cnt == IDX_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                            if (null_cnt != '1) begin
                                null_cnt <= null_cnt + CNT_W'(1);
                            end
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign ogrant    = state;
    assign odrop_cnt = drop_cnt;
    assign osync_err = sync_err;

endmodule

// File: tb/tb_ts_arbiter.sv
// tb_ts_arbiter: directed self-checking bench for ts_arbiter.
module tb_ts_arbiter;

    localparam int PKT = 188;
    localparam int CYC = PKT + 1;

    logic        iclk = 1'b0;
    logic        irst = 1'b1;
    logic        imode = 1'b0;
    logic [7:0]  idat0, idat1;
    logic        isop0, ival0, isop1, ival1;
    logic        irdy = 1'b0;
    logic        ordy0, ordy1;
    logic [7:0]  odat;
    logic        osop, oval;
    logic [1:0]  ogrant;
    logic [15:0] onull_cnt, odrop_cnt;
    logic        osync_err;

    int checks = 0;
    int errors = 0;

    ts_arbiter #(.PKT_LEN(PKT), .CNT_W(16)) dut (
        .iclk      (iclk),
        .irst      (irst),
        .imode     (imode),
        .idat0     (idat0),
        .isop0     (isop0),
        .ival0     (ival0),
        .ordy0     (ordy0),
        .idat1     (idat1),
        .isop1     (isop1),
        .ival1     (ival1),
        .ordy1     (ordy1),
        .odat      (odat),
        .osop      (osop),
        .oval      (oval),
        .irdy      (irdy),
        .ogrant    (ogrant),
        .onull_cnt (onull_cnt),
        .odrop_cnt (odrop_cnt),
        .osync_err (osync_err)
    );

    always #5 iclk = ~iclk;

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1);
    end

    // source models
    logic s_on  [2];
    int   s_idx [2];
    int   s_pre [2];
    int   s_err [2];

    // per-run observations
    int         out_idx, owner, cyc, last_sop_cyc;
    int         st_bytes, st_sop, st_bad, st_len_bad, st_sync;
    logic       first_seen, first_sop, chk_gap;
    logic [1:0] grants[$];

    function automatic logic [7:0] pat(int who, int k);
        if (k == 0) return 8'h47;
        case (who)
            1:       return 8'(k);
            2:       return 8'(k) ^ 8'hA5;
            default: return (k == 1) ? 8'h1F : (k == 3) ? 8'h10 : 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] glog();
        logic [7:0] g;
        g = '0;
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) g[7-2*i -: 2] = grants[i];
        return g;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ival0 = s_on[0];
        isop0 = s_on[0] && s_pre[0] == 0 && (s_idx[0] == 0 || s_idx[0] == s_err[0]);
        idat0 = !s_on[0] ? 8'h00 : (s_pre[0] > 0) ? 8'hEE : pat(1, s_idx[0]);
        ival1 = s_on[1];
        isop1 = s_on[1] && s_pre[1] == 0 && (s_idx[1] == 0 || s_idx[1] == s_err[1]);
        idat1 = !s_on[1] ? 8'h00 : (s_pre[1] > 0) ? 8'hEE : pat(2, s_idx[1]);
    endtask

    task automatic advance(int s);
        if (s_pre[s] > 0) begin
            s_pre[s]--;
        end else begin
            if (s_idx[s] == s_err[s]) s_err[s] = -1;
            s_idx[s] = (s_idx[s] + 1) % PKT;
        end
    endtask

    task automatic observe();
        if (osync_err) st_sync++;
        if (oval && irdy) begin
            if (osop) begin
                if (out_idx != 0) st_len_bad++;
                if (chk_gap && last_sop_cyc >= 0 && (cyc - last_sop_cyc) != CYC) st_len_bad++;
                last_sop_cyc = cyc;
                out_idx = 0;
                owner = int'(ogrant);
                grants.push_back(ogrant);
                st_sop++;
            end
            if (!first_seen) begin
                first_seen = 1'b1;
                first_sop  = osop;
            end
            if (odat !== pat(owner, out_idx) || osop !== (out_idx == 0)) st_bad++;
            out_idx = (out_idx + 1) % PKT;
            st_bytes++;
        end
        if (ival0 && ordy0) advance(0);
        if (ival1 && ordy1) advance(1);
    endtask

    task automatic run(int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) irdy = 1'($urandom_range(0, 1));
            drive();
            @(negedge iclk);
            observe();
            @(posedge iclk);
            #1;
            cyc++;
        end
    endtask

    task automatic clear();
        out_idx = 0; owner = 0; cyc = 0; last_sop_cyc = -1;
        st_bytes = 0; st_sop = 0; st_bad = 0; st_len_bad = 0; st_sync = 0;
        first_seen = 1'b0; first_sop = 1'b0; chk_gap = 1'b1;
        grants.delete();
    endtask

    task automatic do_reset();
        irst = 1'b1;
        irdy = 1'b0;
        for (int s = 0; s < 2; s++) begin
            s_on[s] = 1'b0; s_idx[s] = 0; s_pre[s] = 0; s_err[s] = -1;
        end
        drive();
        repeat (2) @(posedge iclk);
        #1;
        irst = 1'b0;
        clear();
    endtask

    initial begin
        int n;

        // reset state
        do_reset();
        #1;
        chk("rst_outputs", {ogrant, oval, osop, odat, ordy0, ordy1, osync_err}, 0);
        chk("rst_null_cnt", onull_cnt, 0);
        chk("rst_drop_cnt", odrop_cnt, 0);

        // source 0 alone, continuous
        s_on[0] = 1'b1; irdy = 1'b1; imode = 1'b0;
        run(3 * CYC, 0);
        chk("t1_sop_count", st_sop, 3);
        chk("t1_grants", glog(), 8'b01_01_01_00);
        chk("t1_bytes", st_bytes, 3 * PKT);
        chk("t1_data", st_bad, 0);
        chk("t1_len_gap", st_len_bad, 0);
        chk("t1_drops", odrop_cnt, 0);

        // both sources, round robin
        do_reset();
        s_on[0] = 1'b1; s_on[1] = 1'b1; irdy = 1'b1; imode = 1'b0;
        run(4 * CYC, 0);
        chk("t2_rr_grants", glog(), 8'b01_10_01_10);
        chk("t2_rr_data", st_bad, 0);
        chk("t2_rr_len_gap", st_len_bad, 0);

        // both sources, strict priority
        do_reset();
        s_on[0] = 1'b1; s_on[1] = 1'b1; irdy = 1'b1; imode = 1'b1;
        run(4 * CYC, 0);
        chk("t2_pri_grants", glog(), 8'b01_01_01_01);
        chk("t2_pri_sop_count", st_sop, 4);
        chk("t2_pri_data", st_bad, 0);
        imode = 1'b0;

        // no sources
        do_reset();
        irdy = 1'b1;
        run(3 * CYC, 0);
`ifdef TS_ARB_NULL_EN
        chk("t3_null_cnt", onull_cnt, 3);
        chk("t3_null_grants", glog(), 8'b11_11_11_00);
        chk("t3_null_bytes", st_bytes, 3 * PKT);
        chk("t3_null_data", st_bad, 0);
        chk("t3_null_len_gap", st_len_bad, 0);
`else
        chk("t3_idle_bytes", st_bytes, 0);
        chk("t3_idle_grant", ogrant, 0);
        chk("t3_idle_null_cnt", onull_cnt, 0);
`endif

        // source 1 joins mid-packet: five bytes to discard, then a SOP
        do_reset();
        s_on[1] = 1'b1; s_pre[1] = 5; irdy = 1'b0;
        run(6, 0);
        chk("t4_drop_cnt", odrop_cnt, 5);
        chk("t4_grant", ogrant, 2);
        irdy = 1'b1;
        run(PKT, 0);
        chk("t4_first_sop", first_sop, 1);
        chk("t4_grants", glog(), 8'b10_00_00_00);
        chk("t4_bytes", st_bytes, PKT);
        chk("t4_data", st_bad, 0);
        chk("t4_drop_final", odrop_cnt, 5);

        // stray SOP at byte 100
        do_reset();
        s_on[0] = 1'b1; s_err[0] = 100; irdy = 1'b1;
        run(2 * CYC + 7, 0);
        chk("t5_sync_pulses", st_sync, 1);
        chk("t5_data_osop", st_bad, 0);
        chk("t5_len_gap", st_len_bad, 0);
        chk("t5_sop_count", st_sop, 3);

        // random stalls, then reset at byte 50
        do_reset();
        s_on[0] = 1'b1; chk_gap = 1'b0;
        run(600, 1);
        chk("t6_stall_data", st_bad, 0);
        chk("t6_stall_len", st_len_bad, 0);
        chk("t6_stall_some_sop", st_sop > 0, 1);
        n = 0;
        while (!(out_idx == 50 && st_sop > 0) && n < 2000) begin
            run(1, 1);
            n++;
        end
        chk("t6_reach_byte50", n < 2000, 1);
        chk("t6_mid_grant", ogrant, 1);
        irst = 1'b1;
        @(posedge iclk);
        #1;
        irst = 1'b0;
        s_on[0] = 1'b0;
        drive();
        #1;
        chk("t6_rst_outputs", {ogrant, oval, osop, odat, ordy0, ordy1, osync_err}, 0);
        chk("t6_rst_counters", {onull_cnt, odrop_cnt}, 0);
        s_idx[0] = 0; s_pre[0] = 0; s_err[0] = -1; s_on[0] = 1'b1;
        clear();
        irdy = 1'b1;
        run(CYC, 0);
        chk("t6_post_first_sop", first_sop, 1);
        chk("t6_post_bytes", st_bytes, PKT);
        chk("t6_post_data", st_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
